// File: rtl/rstseq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rstseq_pkg
// Purpose  : Shared constants for the vending-core reset sequencer: state
//            encoding, fault-counter ceiling, default parameter values and a
//            small helper used to size the shared hold/wake counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rstseq_pkg;

    // FSM state encoding
    localparam logic [1:0] RST_S_RESET = 2'd0;
    localparam logic [1:0] RST_S_HOLD  = 2'd1;
    localparam logic [1:0] RST_S_WAKE  = 2'd2;
    localparam logic [1:0] RST_S_RUN   = 2'd3;

    // Saturation value of the wake-timeout counter
    localparam logic [3:0] FAULT_MAX = 4'd15;

    // Default parameter values
    localparam int SYNC_STAGES_DEF = 2;
    localparam int HOLD_CYCLES_DEF = 16;
    localparam int ACK_TIMEOUT_DEF = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sync.sv
`default_nettype none
// ============================================================================
// Module   : reset_sync
// Purpose  : STAGES-deep flop chain bringing an asynchronous active-high
//            request into the clk domain. Every flop presets to 1 so the
//            request reads as asserted while the block is held in reset.
// Ports    : clk  - system clock
//            rst  - asynchronous active-high preset
//            i_d  - asynchronous input
//            o_q  - synchronised output (last stage)
// Revision : 1.0 - initial release
// ============================================================================
module reset_sync
    import rstseq_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Reset release sequencer for the vending machine core. Holds the
//            core in reset while the combined request is present, releases it
//            after HOLD_CYCLES quiet cycles, then runs a wake/ack handshake
//            with the vending FSM and counts wake-up timeouts.
// Ports    : clk     - system clock, rising edge
//            resetin - master reset, asynchronous, active-high
//            rstreq  - combined reset request, asynchronous, active-high
//            ack     - wake-up acknowledge from the vending FSM
//            rstout  - core reset, registered, active-high
//            wake    - high while waiting for ack
//            ready   - high while the core is running
//            faults  - saturating count of wake timeouts (cleared by resetin)
// Config   : RSTSEQ_GLITCH_FILTER_EN - when defined, WAKE/RUN only react to a
//            synchronised request that has been high for two cycles.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       resetin,
    input  logic       rstreq,
    input  logic       ack,
    output logic       rstout,
    output logic       wake,
    output logic       ready,
    output logic [3:0] faults
);

    localparam int c_cnt_w = $clog2(max_int(HOLD_CYCLES, ACK_TIMEOUT));
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_ack_last  = c_cnt_w'(ACK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    logic               w_req_s;
    logic               w_req_run;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [3:0]         r_faults;
    logic [3:0]         w_faults_nxt;
    logic               r_rstout;
    logic               r_wake;
    logic               r_ready;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (resetin),
        .i_d (rstreq),
        .o_q (w_req_s)
    );

`ifdef RSTSEQ_GLITCH_FILTER_EN
    // Second look at req_s: a request seen by WAKE/RUN must persist for two
    // consecutive synchronised samples. RESET/HOLD keep using raw req_s so a
    // single blip during the hold still restarts the release.
    logic r_req_d;

    always_ff @(posedge clk or posedge resetin) begin
        if (resetin) begin
            r_req_d <= 1'b1;
        end else begin
            r_req_d <= w_req_s;
        end
    end

    assign w_req_run = w_req_s & r_req_d;
`else
    assign w_req_run = w_req_s;
`endif

    always_ff @(posedge clk or posedge resetin) begin
        if (resetin) begin
            r_state  <= RST_S_RESET;
            r_cnt    <= '0;
            r_faults <= '0;
            r_rstout <= 1'b1;
            r_wake   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_faults <= w_faults_nxt;
            // Outputs decoded from the next state so they change exactly with
            // the state register and never glitch.
            r_rstout <= (w_state_nxt == RST_S_RESET) || (w_state_nxt == RST_S_HOLD);
            r_wake   <= (w_state_nxt == RST_S_WAKE);
            r_ready  <= (w_state_nxt == RST_S_RUN);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_faults_nxt = r_faults;
        case (r_state)
            RST_S_RESET: begin
                w_cnt_nxt = '0;
                if (!w_req_s) begin
                    w_state_nxt = RST_S_HOLD;
                end
            end
            RST_S_HOLD: begin
                if (w_req_s) begin
                    w_state_nxt = RST_S_RESET;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_hold_last) begin
                    w_state_nxt = RST_S_WAKE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            RST_S_WAKE: begin
                // Request beats ack, ack beats timeout.
                if (w_req_run) begin
                    w_state_nxt = RST_S_RESET;
                    w_cnt_nxt   = '0;
                end else if (ack) begin
                    w_state_nxt = RST_S_RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_ack_last) begin
                    w_state_nxt = RST_S_RESET;
                    w_cnt_nxt   = '0;
                    if (r_faults != FAULT_MAX) begin
                        w_faults_nxt = r_faults + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            RST_S_RUN: begin
                if (w_req_run) begin
                    w_state_nxt = RST_S_RESET;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = RST_S_RESET;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign rstout = r_rstout;
    assign wake   = r_wake;
    assign ready  = r_ready;
    assign faults = r_faults;

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Reset release sequencer for the vending machine core. It consumes the combined, unsynchronised reset request produced by the reset-combining logic (master reset OR'd with the inverted machine-enable). It asserts the core reset within a bounded number of clocks and releases it only after the request has stayed low for a programmable hold time. It then runs a wake/ack handshake with the vending FSM and counts failed wake-ups.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth for `rstreq`; minimum 2.
- HOLD_CYCLES, 16: consecutive low-request cycles required before release; minimum 2.
- ACK_TIMEOUT, 8: WAKE cycles allowed before a fault; minimum 2.

Ports:
- clk  in  1  single system clock, rising edge.
- resetin  in  1  master reset, asynchronous, active-high (already decided).
- rstreq  in  1  combined reset request, asynchronous to `clk`, active-high.
- ack  in  1  vending FSM acknowledges wake-up, synchronous.
- rstout  out  1  core reset, registered, active-high.
- wake  out  1  high in WAKE only.
- ready  out  1  high in RUN only.
- faults  out  4  saturating count of wake timeouts.

## Operation
- `rstreq` passes through a SYNC_STAGES flop chain; the last stage is `req_s`. All chain flops reset to 1.
- FSM states are RESET, HOLD, WAKE and RUN. A single counter `cnt` is shared; its width is clog2(max(HOLD_CYCLES, ACK_TIMEOUT)).
- RESET: rstout=1. If req_s=0, go to HOLD with cnt=0.
- HOLD: rstout=1. If req_s=1, go to RESET. If cnt==HOLD_CYCLES-1, go to WAKE with cnt=0. Otherwise cnt+1.
- WAKE: rstout=0, wake=1. If ack=1, go to RUN. If cnt==ACK_TIMEOUT-1, go to RESET and faults+1, saturating at 15. Otherwise cnt+1.
- RUN: rstout=0, ready=1. Stay in RUN until a request arrives.
- Request priority: req_s=1 in any state forces RESET on the next edge. It overrides ack and timeout, and no fault is counted.
- ack outside WAKE is ignored.
- rstreq never clears `faults`; only resetin does.
- Outputs are registered and decoded from the next state, so no output glitches.

## Timing
- resetin=1, asynchronously: state=RESET, rstout=1, wake=0, ready=0, faults=0, cnt=0, sync chain all 1.
- Release after reset, with rstreq already low:
  - req_s=0 after edge SYNC_STAGES.
  - HOLD entered at edge SYNC_STAGES+1.
  - rstout falls and wake rises at edge SYNC_STAGES+1+HOLD_CYCLES, which is edge 19 with the defaults.
- Request assertion latency: rstreq rising to rstout=1 takes SYNC_STAGES+1 edges (3 with the defaults), or one more edge with the glitch filter.
- ack sampled high in WAKE: ready=1 and wake=0 on the next edge.
- Timeout: wake stays high for exactly ACK_TIMEOUT cycles, then rstout=1 and faults increments on the same edge.
- Simultaneous ack and cnt==ACK_TIMEOUT-1: ack wins and the FSM goes to RUN with no fault.
- resetin asserted mid-sequence discards all progress, including `faults`.

## Configuration
- Macro: `RSTSEQ_GLITCH_FILTER_EN`.
- Defined: an extra flop follows `req_s`. A request is recognised only when req_s has been 1 for 2 consecutive cycles, so single-cycle synchronised pulses are ignored. Assertion latency becomes SYNC_STAGES+2. Release behaviour is unchanged: any single req_s=1 in HOLD still restarts the sequence.
- Undefined: a single req_s=1 sample triggers RESET.

## Structure
- Shared package/header `rstseq_pkg` holds:
  - the state encoding constants RST_S_RESET=2'd0, RST_S_HOLD=2'd1, RST_S_WAKE=2'd2, RST_S_RUN=2'd3;
  - the FAULT_MAX=4'd15 constant;
  - the default parameter values.
- One sub-module, `reset_sync`: a parameterised SYNC_STAGES flop chain with asynchronous preset to 1, instantiated once for `rstreq`.
- The FSM, counter and fault counter live in the top module.

## Test plan
All scenarios use the defaults (SYNC_STAGES=2, HOLD_CYCLES=16, ACK_TIMEOUT=8).
1. Power-up: pulse resetin with rstreq=0 → rstout=1 until edge 19 after resetin falls, then rstout=0 and wake=1. faults=0 throughout.
2. Handshake: ack=1 on the 3rd WAKE cycle → ready=1 and wake=0 on the next edge. rstout stays 0.
3. Timeout: hold ack=0 → RESET after 8 WAKE cycles with faults=1. Repeat 16 timeouts → faults saturates at 15. A resetin pulse then clears it to 0.
4. Re-request in HOLD: rstreq=1 for 3 cycles when cnt=10 → back to RESET. After rstreq falls, a full 16-cycle hold elapses before WAKE, and faults is unchanged.
5. Glitch: a 1-cycle rstreq pulse (aligned to clk) in RUN:
   - without the macro → rstout=1 3 edges later;
   - with `RSTSEQ_GLITCH_FILTER_EN` → state stays RUN.
   A 2-cycle pulse with the macro → rstout=1 4 edges later.
6. Priority: in WAKE at cnt=7, drive ack=1 and have req_s=1 on the same edge → RESET, ready stays 0, faults unchanged.
